// File: rtl/vlsu_stride.sv
// Strided vector load/store unit: moves one VLEN-bit vector register between
// the vector register file and memory over the X-IF memory interface, with a
// signed byte stride, runtime vector length, pipelined loads and fault reporting.

package cv32e40x_xif_pkg;
   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [1:0]  mode;
      logic        we;
      logic [2:0]  size;
      logic [3:0]  be;
      logic [1:0]  attr;
      logic [31:0] wdata;
      logic        last;
      logic        spec;
   } x_mem_req_t;

   typedef struct packed {
      logic       exc;
      logic [5:0] exccode;
      logic       dbg;
   } x_mem_resp_t;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] rdata;
      logic        err;
      logic        dbg;
   } x_mem_result_t;
endpackage

module vlsu_stride
   import cv32e40x_xif_pkg::*;
#(
   parameter int VLEN            = 256,
   parameter int X_ID_WIDTH      = 4,
   parameter int MAX_OUTSTANDING = 4,
   localparam int WORDS          = VLEN / 32,
   localparam int CW             = $clog2(WORDS) + 1
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  start_i,
   input  logic                  is_store_i,
   input  logic [31:0]           base_addr_i,
   input  logic [31:0]           stride_i,
   input  logic [CW-1:0]         vl_i,
   input  logic [X_ID_WIDTH-1:0] id_i,
   input  logic [VLEN-1:0]       store_data_i,
   output logic [VLEN-1:0]       load_data_o,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  error_o,
   output logic [CW-1:0]         error_idx_o,
   output logic                  xif_mem_valid_o,
   input  logic                  xif_mem_ready_i,
   output x_mem_req_t            xif_mem_req_o,
   input  x_mem_resp_t           xif_mem_resp_i,
   input  logic                  xif_mem_result_valid_i,
   input  x_mem_result_t         xif_mem_result_i
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           issue_cnt, recv_cnt, vlc, err_idx_q;
   logic [OW-1:0]           outstanding, out_nxt;
   logic [31:0]             addr_q, stride_q;
   logic [X_ID_WIDTH-1:0]   id_q;
   logic                    st_q, err_q, hold_q;
   logic [WORDS-1:0][31:0]  ld_q, st_w;

   logic          start_acc, hs, hs_exc, res_acc, res_err, res_wr, new_fault;
   logic          can_issue, issue_end, inc, dec;
   logic [CW-1:0] vl_c, fault_idx;
   logic          unused_ok;

   assign st_w      = store_data_i;
   assign start_acc = (state_q == IDLE) && start_i;
   assign vl_c      = (vl_i > CW'(WORDS)) ? CW'(WORDS) : vl_i;
   assign unused_ok = ^{xif_mem_resp_i.exccode, xif_mem_resp_i.dbg,
                        xif_mem_result_i.id, xif_mem_result_i.dbg};

   // handshake, result acceptance and fault detection
   always_comb begin
      can_issue = (issue_cnt < vlc) && !err_q &&
                  (st_q || (outstanding < OW'(MAX_OUTSTANDING)));
      xif_mem_valid_o = (state_q == ISSUE) && (hold_q || can_issue);
      hs        = xif_mem_valid_o && xif_mem_ready_i;
      hs_exc    = hs && xif_mem_resp_i.exc;
      // a result with nothing outstanding is stale and dropped
      res_acc   = xif_mem_result_valid_i && (outstanding != '0);
      res_err   = res_acc && xif_mem_result_i.err;
      new_fault = !err_q && (hs_exc || res_err);
      // a result fault always belongs to an older element than the request
      fault_idx = res_err ? recv_cnt : issue_cnt;
      res_wr    = res_acc && !xif_mem_result_i.err &&
                  !(err_q && (recv_cnt >= err_idx_q));
      // a faulted request is never performed, so no result will follow it
      inc       = hs && !st_q && !xif_mem_resp_i.exc;
      dec       = res_acc;
      out_nxt   = outstanding + OW'(inc) - OW'(dec);
      if (hs)
         issue_end = (issue_cnt + CW'(1) == vlc) || err_q || new_fault;
      else
         issue_end = !xif_mem_valid_o && (err_q || new_fault || (issue_cnt == vlc));
   end

   // request fields, zero whenever valid is low
   always_comb begin
      xif_mem_req_o = '0;
      if (xif_mem_valid_o) begin
         xif_mem_req_o.id   = id_q;
         xif_mem_req_o.addr = addr_q;
         xif_mem_req_o.mode = 2'b11;
         xif_mem_req_o.we   = st_q;
         xif_mem_req_o.size = 3'b010;
         xif_mem_req_o.be   = 4'b1111;
         xif_mem_req_o.last = (issue_cnt == vlc - CW'(1));
         if (st_q)
            for (int i = 0; i < WORDS; i++)
               if (issue_cnt == CW'(i)) xif_mem_req_o.wdata = st_w[i];
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (start_i) state_d = (vl_c == '0) ? DONE : ISSUE;
         ISSUE: if (issue_end) state_d = (out_nxt == '0) ? DONE : DRAIN;
         DRAIN: if (outstanding == '0) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // operation context, counters and fault record
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         vlc         <= '0;
         outstanding <= '0;
         addr_q      <= '0;
         stride_q    <= '0;
         id_q        <= '0;
         st_q        <= 1'b0;
         err_q       <= 1'b0;
         err_idx_q   <= '0;
         hold_q      <= 1'b0;
      end else if (start_acc) begin
         issue_cnt   <= '0;
         recv_cnt    <= '0;
         vlc         <= vl_c;
         outstanding <= '0;
         addr_q      <= base_addr_i;
         stride_q    <= stride_i;
         id_q        <= id_i;
         st_q        <= is_store_i;
         err_q       <= 1'b0;
         err_idx_q   <= '0;
         hold_q      <= 1'b0;
      end else begin
         if (hs) begin
            issue_cnt <= issue_cnt + CW'(1);
            addr_q    <= addr_q + stride_q;
         end
         if (res_acc) recv_cnt <= recv_cnt + CW'(1);
         outstanding <= out_nxt;
         // once raised, valid stays up until the memory takes the request
         hold_q      <= xif_mem_valid_o && !xif_mem_ready_i;
         if (new_fault) begin
            err_q     <= 1'b1;
            err_idx_q <= fault_idx;
         end
      end
   end

   // per-word load result register
   for (genvar g = 0; g < WORDS; g++) begin : g_word
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni)                                ld_q[g] <= '0;
         else if (start_acc && !is_store_i)          ld_q[g] <= '0;
         else if (res_wr && (recv_cnt == CW'(g)))    ld_q[g] <= xif_mem_result_i.rdata;
      end
   end

   assign load_data_o = ld_q;
   assign busy_o      = (state_q != IDLE);
   assign done_o      = (state_q == DONE);
   assign error_o     = done_o && err_q;
   assign error_idx_o = error_o ? err_idx_q : '0;

endmodule

// File: tb/tb_vlsu_stride.sv
// Directed bench for vlsu_stride with a behavioural X-IF memory responder.
module tb_vlsu_stride;
   import cv32e40x_xif_pkg::*;

   localparam int VLEN = 256;
   localparam int CW   = 4;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            start = 1'b0, is_store = 1'b0;
   logic [31:0]     base = '0, stride = '0;
   logic [CW-1:0]   vl = '0;
   logic [3:0]      id = 4'h5;
   logic [VLEN-1:0] store_data = '0;
   logic [VLEN-1:0] load_data;
   logic            busy, done, error;
   logic [CW-1:0]   error_idx;
   logic            mvalid, mready = 1'b0, rvalid = 1'b0;
   x_mem_req_t      req;
   x_mem_resp_t     resp = '0;
   x_mem_result_t   result = '0;

   always #5 clk = ~clk;

   vlsu_stride #(.VLEN(VLEN), .X_ID_WIDTH(4), .MAX_OUTSTANDING(4)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .is_store_i(is_store),
      .base_addr_i(base), .stride_i(stride), .vl_i(vl), .id_i(id),
      .store_data_i(store_data), .load_data_o(load_data), .busy_o(busy),
      .done_o(done), .error_o(error), .error_idx_o(error_idx),
      .xif_mem_valid_o(mvalid), .xif_mem_ready_i(mready), .xif_mem_req_o(req),
      .xif_mem_resp_i(resp), .xif_mem_result_valid_i(rvalid),
      .xif_mem_result_i(result));

   // memory model configuration (written only by the stimulus block)
   int lat = 1, ready_mode = 0, exc_idx = -1;
   // memory model state (written only by the responder)
   int hs_cnt = 0, ncyc = 0, tb_out = 0, max_out = 0, stab_err = 0;
   logic [31:0] pend_addr[$];
   int          pend_due[$];
   logic [31:0] log_addr[$], log_wdata[$];
   logic        log_last[$], log_we[$];
   logic        hold_pend = 1'b0;
   x_mem_req_t  hold_req = '0;

   // responder: drives ready/exc/results for the coming edge, logs handshakes
   always @(negedge clk) begin
      ncyc++;
      if (hold_pend && rst_n && (!mvalid || req !== hold_req)) stab_err++;
      if (pend_due.size() > 0 && pend_due[0] <= ncyc) begin
         rvalid       = 1'b1;
         result       = '0;
         result.rdata = pend_addr[0] ^ 32'hA5A5A5A5;
         void'(pend_addr.pop_front());
         void'(pend_due.pop_front());
         tb_out--;
      end else begin
         rvalid = 1'b0;
         result = '0;
      end
      mready   = (ready_mode == 0) ? 1'b1 : ((ncyc % 2) == 0);
      resp     = '0;
      resp.exc = (hs_cnt == exc_idx);
      if (mvalid && mready) begin
         log_addr.push_back(req.addr);
         log_wdata.push_back(req.wdata);
         log_last.push_back(req.last);
         log_we.push_back(req.we);
         if (!req.we && !resp.exc) begin
            pend_addr.push_back(req.addr);
            pend_due.push_back(ncyc + lat);
            tb_out++;
            if (tb_out > max_out) max_out = tb_out;
         end
         hs_cnt++;
      end
      hold_pend = mvalid && !mready;
      hold_req  = req;
   end

   int checks = 0, passes = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic start_op(input logic st, input logic [31:0] b, input logic [31:0] s,
                           input logic [CW-1:0] n);
      @(negedge clk);
      start = 1'b1; is_store = st; base = b; stride = s; vl = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int maxc, output int l, output logic e,
                            output logic [CW-1:0] ei);
      l = -1; e = 1'bx; ei = 'x;
      for (int k = 1; k <= maxc; k++) begin
         if (done) begin l = k; e = error; ei = error_idx; break; end
         @(negedge clk);
      end
      chk("done_seen", (l > 0), 1'b1);
      @(negedge clk);
      chk("done_single", done, 1'b0);
   endtask

   function automatic logic [31:0] word(input logic [VLEN-1:0] v, input int i);
      return v[i*32 +: 32];
   endfunction

   initial begin
      int l, h0;
      logic e;
      logic [CW-1:0] ei;
      logic [31:0] st_addr[3];
      st_addr[0] = 32'h2000; st_addr[1] = 32'h1FF8; st_addr[2] = 32'h1FF0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 1'b0);
      chk("rst_valid", mvalid, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ldata", |load_data, 1'b0);
      rst_n = 1'b1;

      // unit-stride load, 1-cycle latency
      h0 = hs_cnt;
      start_op(1'b0, 32'h1000, 32'd4, 4'd8);
      wait_done(40, l, e, ei);
      chk("ul_lat", l, 11);
      chk("ul_err", e, 1'b0);
      chk("ul_hs", hs_cnt - h0, 8);
      chk("ul_maxout", (max_out <= 4), 1'b1);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("ul_addr%0d", i), log_addr[h0+i], 32'h1000 + 4*i);
         chk($sformatf("ul_last%0d", i), log_last[h0+i], (i == 7));
         chk($sformatf("ul_data%0d", i), word(load_data, i), (32'h1000 + 4*i) ^ 32'hA5A5A5A5);
      end

      // strided store, negative stride, toggling ready
      for (int i = 0; i < 8; i++) store_data[i*32 +: 32] = 32'h1111_0000 + i;
      ready_mode = 1;
      h0 = hs_cnt;
      start_op(1'b1, 32'h2000, -32'sd8, 4'd3);
      wait_done(40, l, e, ei);
      chk("st_hs", hs_cnt - h0, 3);
      chk("st_err", e, 1'b0);
      chk("st_stable", stab_err, 0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("st_addr%0d", i), log_addr[h0+i], st_addr[i]);
         chk($sformatf("st_wdata%0d", i), log_wdata[h0+i], 32'h1111_0000 + i);
         chk($sformatf("st_last%0d", i), log_last[h0+i], (i == 2));
         chk($sformatf("st_we%0d", i), log_we[h0+i], 1'b1);
      end

      // store with ready always high: done n+1 cycles after start
      ready_mode = 0;
      start_op(1'b1, 32'h2100, 32'd4, 4'd2);
      wait_done(40, l, e, ei);
      chk("st2_lat", l, 3);

      // long latency load hits the outstanding limit
      lat = 6;
      h0 = hs_cnt;
      start_op(1'b0, 32'h4000, 32'd4, 4'd5);
      for (int k = 0; k < 20 && (hs_cnt - h0) < 4; k++) @(negedge clk);
      @(negedge clk);
      chk("lim_valid_low", mvalid, 1'b0);
      chk("lim_hs4", hs_cnt - h0, 4);
      wait_done(60, l, e, ei);
      chk("lim_hs5", hs_cnt - h0, 5);
      for (int i = 0; i < 5; i++)
         chk($sformatf("lim_data%0d", i), word(load_data, i), (32'h4000 + 4*i) ^ 32'hA5A5A5A5);
      for (int i = 5; i < 8; i++)
         chk($sformatf("lim_zero%0d", i), word(load_data, i), 32'h0);

      // vl = 0: no request, immediate completion
      lat = 1;
      h0 = hs_cnt;
      start_op(1'b0, 32'h0, 32'd4, 4'd0);
      wait_done(10, l, e, ei);
      chk("vl0_lat", l, 1);
      chk("vl0_hs", hs_cnt - h0, 0);

      // vl = 12 clamps to 8
      h0 = hs_cnt;
      start_op(1'b0, 32'h800, 32'd4, 4'd12);
      wait_done(40, l, e, ei);
      chk("clamp_hs", hs_cnt - h0, 8);

      // exception on element 3's handshake
      h0 = hs_cnt;
      exc_idx = h0 + 3;
      start_op(1'b0, 32'h5000, 32'd4, 4'd8);
      wait_done(40, l, e, ei);
      exc_idx = -1;
      chk("exc_hs", hs_cnt - h0, 4);
      chk("exc_err", e, 1'b1);
      chk("exc_idx", ei, 4'd3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("exc_data%0d", i), word(load_data, i), (32'h5000 + 4*i) ^ 32'hA5A5A5A5);
      chk("exc_data3", word(load_data, 3), 32'h0);

      // reset mid-load, stale results afterwards, then a clean transfer
      lat = 6;
      h0 = hs_cnt;
      start_op(1'b0, 32'h6000, 32'd4, 4'd8);
      for (int k = 0; k < 20 && (hs_cnt - h0) < 2; k++) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_busy", busy, 1'b0);
      chk("mr_valid", mvalid, 1'b0);
      chk("mr_done", done, 1'b0);
      chk("mr_ldata", |load_data, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 20 && pend_due.size() > 0; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("stale_busy", busy, 1'b0);
      chk("stale_ldata", |load_data, 1'b0);
      lat = 1;
      start_op(1'b0, 32'h7000, 32'd4, 4'd2);
      wait_done(40, l, e, ei);
      chk("post_err", e, 1'b0);
      chk("post_data0", word(load_data, 0), 32'h7000 ^ 32'hA5A5A5A5);
      chk("post_data1", word(load_data, 1), 32'h7004 ^ 32'hA5A5A5A5);
      chk("post_data2", word(load_data, 2), 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL timeout");
   end
endmodule
